// File: rtl/vend_pkg.sv
// Shared definitions for the parametrised vending controller:
// state encoding and default parameter values.
package vend_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    REFUND  = 1'b1
  } state_e;

  localparam int DEF_CREDIT_W   = 4;
  localparam int DEF_COIN_W     = 2;
  localparam int DEF_PRICE      = 4;
  localparam int DEF_MAX_CREDIT = 15;
  localparam int DEF_CHG_BIG    = 2;

endpackage

// File: rtl/vend_chg_sel.sv
// Change denomination chooser: picks the large coin while it fits,
// otherwise the unit coin, and reports the matching decrement.
module vend_chg_sel #(
  parameter int CREDIT_W = 4,
  parameter int CHG_BIG  = 2
) (
  input  logic [CREDIT_W-1:0] credit,
  output logic                big,
  output logic [CREDIT_W-1:0] dec
);

  localparam logic [CREDIT_W-1:0] BIG_V = CREDIT_W'(CHG_BIG);
  localparam logic [CREDIT_W-1:0] ONE_V = CREDIT_W'(1);

  assign big = (credit >= BIG_V);
  assign dec = big ? BIG_V : ONE_V;

endmodule

// File: rtl/vend_param.sv
// Parametrised vending controller: saturating credit, dispense pulse,
// and a ready/valid change port paying out overpayment or refunds.
module vend_param
  import vend_pkg::*;
#(
  parameter int CREDIT_W   = DEF_CREDIT_W,
  parameter int COIN_W     = DEF_COIN_W,
  parameter int PRICE      = DEF_PRICE,
  parameter int MAX_CREDIT = DEF_MAX_CREDIT,
  parameter int CHG_BIG    = DEF_CHG_BIG
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                coin_vld,
  input  logic [COIN_W-1:0]   coin_val,
  input  logic                cancel,
  output logic                t,
  output logic                coin_rej,
  output logic                chg_vld,
  output logic                chg_big,
  input  logic                chg_rdy,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam int SW = CREDIT_W + 1;
  localparam logic [SW-1:0] PRICE_S = SW'(PRICE);
  localparam logic [SW-1:0] MAX_S   = SW'(MAX_CREDIT);

  if (PRICE < 1 || PRICE > MAX_CREDIT ||
      MAX_CREDIT >= 2**CREDIT_W ||
      CHG_BIG < 1 || CHG_BIG >= 2**CREDIT_W) begin : g_bad_params
    $error("vend_param: invalid parameter set");
  end

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                t_q, t_d;
  logic                rej_q, rej_d;
  logic [SW-1:0]       sum;
  logic                coin;
  logic                sel_big;
  logic [CREDIT_W-1:0] dec;

  vend_chg_sel #(
    .CREDIT_W (CREDIT_W),
    .CHG_BIG  (CHG_BIG)
  ) u_chg_sel (
    .credit (credit_q),
    .big    (sel_big),
    .dec    (dec)
  );

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    t_d      = 1'b0;
    rej_d    = 1'b0;
    coin     = coin_vld && (coin_val != '0);
    sum      = {1'b0, credit_q} + SW'(coin_val);
    unique case (state_q)
      COLLECT: begin
        if (coin && sum > MAX_S) begin
          rej_d = 1'b1;
          if (cancel && credit_q != '0) state_d = REFUND;
        end else if (coin && sum >= PRICE_S) begin
          // purchase wins over cancel; any remainder is paid back
          t_d      = 1'b1;
          credit_d = CREDIT_W'(sum - PRICE_S);
          if (sum != PRICE_S) state_d = REFUND;
        end else if (coin) begin
          credit_d = CREDIT_W'(sum);
          if (cancel) state_d = REFUND;
        end else if (cancel && credit_q != '0) begin
          state_d = REFUND;
        end
      end
      REFUND: begin
        rej_d = coin_vld;
        if (chg_rdy) begin
          credit_d = credit_q - dec;
          if (credit_q == dec) state_d = COLLECT;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= COLLECT;
      credit_q <= '0;
      t_q      <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      t_q      <= t_d;
      rej_q    <= rej_d;
    end
  end

  assign t        = t_q;
  assign coin_rej = rej_q;
  assign busy     = (state_q == REFUND);
  assign chg_vld  = busy;
  assign chg_big  = busy & sel_big;
  assign credit   = credit_q;

endmodule

// File: tb/tb_vend_param.sv
// Bench for vend_param: three price configurations driven in parallel
// and checked every cycle against a behavioural model.
module tb_vend_param;

  localparam int N    = 3;
  localparam int MAXC = 15;
  localparam int BIGC = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       coin_vld = 1'b0;
  logic [1:0] coin_val = 2'd0;
  logic       cancel = 1'b0;
  logic       chg_rdy = 1'b0;

  logic       t_o   [N];
  logic       rej_o [N];
  logic       cv_o  [N];
  logic       cb_o  [N];
  logic [3:0] cr_o  [N];
  logic       busy_o[N];

  int n_chk = 0;
  int n_fail = 0;

  int price_m[N] = '{4, 12, 15};
  int m_cred [N] = '{0, 0, 0};
  bit m_ref  [N] = '{0, 0, 0};
  bit m_t    [N] = '{0, 0, 0};
  bit m_rej  [N] = '{0, 0, 0};

  always #5 clk = ~clk;

  vend_param u_a (
    .clk(clk), .reset_n(reset_n), .coin_vld(coin_vld),
    .coin_val(coin_val), .cancel(cancel), .t(t_o[0]),
    .coin_rej(rej_o[0]), .chg_vld(cv_o[0]), .chg_big(cb_o[0]),
    .chg_rdy(chg_rdy), .credit(cr_o[0]), .busy(busy_o[0])
  );

  vend_param #(.PRICE(12)) u_b (
    .clk(clk), .reset_n(reset_n), .coin_vld(coin_vld),
    .coin_val(coin_val), .cancel(cancel), .t(t_o[1]),
    .coin_rej(rej_o[1]), .chg_vld(cv_o[1]), .chg_big(cb_o[1]),
    .chg_rdy(chg_rdy), .credit(cr_o[1]), .busy(busy_o[1])
  );

  vend_param #(.PRICE(15)) u_c (
    .clk(clk), .reset_n(reset_n), .coin_vld(coin_vld),
    .coin_val(coin_val), .cancel(cancel), .t(t_o[2]),
    .coin_rej(rej_o[2]), .chg_vld(cv_o[2]), .chg_big(cb_o[2]),
    .chg_rdy(chg_rdy), .credit(cr_o[2]), .busy(busy_o[2])
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: one vending machine per configuration.
  always @(posedge clk or negedge reset_n) begin : mdl
    int c, s, pay;
    bit r, tt, rj;
    for (int k = 0; k < N; k++) begin
      if (!reset_n) begin
        m_cred[k] <= 0; m_ref[k] <= 0;
        m_t[k] <= 0; m_rej[k] <= 0;
      end else begin
        c = m_cred[k]; r = m_ref[k]; tt = 0; rj = 0;
        if (r) begin
          if (coin_vld) rj = 1;
          if (chg_rdy) begin
            pay = (c >= BIGC) ? BIGC : 1;
            c = c - pay;
            if (c == 0) r = 0;
          end
        end else begin
          if (coin_vld && coin_val != 0) begin
            s = c + int'(coin_val);
            if (s > MAXC) rj = 1;
            else if (s >= price_m[k]) begin tt = 1; c = s - price_m[k]; end
            else c = s;
          end
          if (tt) r = (c > 0);
          else if (cancel && c > 0) r = 1;
        end
        m_cred[k] <= c; m_ref[k] <= r; m_t[k] <= tt; m_rej[k] <= rj;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      chk($sformatf("t[%0d]", k), int'(t_o[k]), int'(m_t[k]));
      chk($sformatf("coin_rej[%0d]", k), int'(rej_o[k]), int'(m_rej[k]));
      chk($sformatf("chg_vld[%0d]", k), int'(cv_o[k]), int'(m_ref[k]));
      chk($sformatf("chg_big[%0d]", k), int'(cb_o[k]),
          int'(m_ref[k] && m_cred[k] >= BIGC));
      chk($sformatf("credit[%0d]", k), int'(cr_o[k]), m_cred[k]);
      chk($sformatf("busy[%0d]", k), int'(busy_o[k]), int'(m_ref[k]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input int v);
    coin_vld = 1'b1;
    coin_val = 2'(v);
    tick();
    coin_vld = 1'b0;
    coin_val = 2'd0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  int exp_big[4]  = '{1, 1, 1, 0};
  int exp_left[4] = '{5, 3, 1, 0};

  initial begin
    int f0;
    bit done;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // reset in the middle of a refund
    coin(3);
    coin(2);
    chk("A t after 3+2", int'(t_o[0]), 1);
    chk("A credit after 3+2", int'(cr_o[0]), 1);
    chk("A busy after 3+2", int'(busy_o[0]), 1);
    tick();
    reset_n = 1'b0;
    #1;
    chk("A rst credit", int'(cr_o[0]), 0);
    chk("A rst chg_vld", int'(cv_o[0]), 0);
    chk("A rst busy", int'(busy_o[0]), 0);
    chk("B rst credit", int'(cr_o[1]), 0);
    tick();
    reset_n = 1'b1;

    // four unit coins reach the default price
    coin_vld = 1'b1; coin_val = 2'd1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("A t unit coins", int'(t_o[0]), (i == 3) ? 1 : 0);
    end
    coin_vld = 1'b0; coin_val = 2'd0;
    chk("A credit exact", int'(cr_o[0]), 0);
    chk("A busy exact", int'(busy_o[0]), 0);
    tick();
    chk("A t one cycle", int'(t_o[0]), 0);

    // overpayment
    coin(2);
    coin(2);
    chk("A t 2+2", int'(t_o[0]), 1);
    chk("A credit 2+2", int'(cr_o[0]), 0);
    coin(1); coin(2); coin(2);
    chk("A t 1+2+2", int'(t_o[0]), 1);
    chk("A credit 1+2+2", int'(cr_o[0]), 1);
    chk("A chg_vld overpay", int'(cv_o[0]), 1);
    chk("A chg_big overpay", int'(cb_o[0]), 0);
    chg_rdy = 1'b1;
    tick();
    chg_rdy = 1'b0;
    chk("A credit paid", int'(cr_o[0]), 0);
    chk("A chg_vld done", int'(cv_o[0]), 0);

    // cancel at PRICE=12 with stall mid-sequence
    do_reset();
    coin(3); coin(3); coin(1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("B busy cancel", int'(busy_o[1]), 1);
    chk("B credit cancel", int'(cr_o[1]), 7);
    chk("model B credit", m_cred[1], 7);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        chg_rdy = 1'b0;
        for (int j = 0; j < 3; j++) begin
          tick();
          chk("B stall credit", int'(cr_o[1]), 3);
          chk("B stall vld", int'(cv_o[1]), 1);
          chk("B stall big", int'(cb_o[1]), 1);
        end
      end
      chg_rdy = 1'b1;
      chk("B chg_big seq", int'(cb_o[1]), exp_big[i]);
      tick();
      chk("B credit seq", int'(cr_o[1]), exp_left[i]);
    end
    chg_rdy = 1'b0;
    chk("B busy end", int'(busy_o[1]), 0);
    chk("B chg_vld end", int'(cv_o[1]), 0);

    // saturation at PRICE=15
    do_reset();
    coin(3); coin(3); coin(3); coin(3); coin(2);
    chk("C credit 14", int'(cr_o[2]), 14);
    chk("model C credit", m_cred[2], 14);
    coin(3);
    chk("C rej sat", int'(rej_o[2]), 1);
    chk("C t sat", int'(t_o[2]), 0);
    chk("C credit sat", int'(cr_o[2]), 14);
    coin(1);
    chk("C t at max", int'(t_o[2]), 1);
    chk("C credit at max", int'(cr_o[2]), 0);
    coin(3); coin(3); coin(3); coin(3); coin(2);
    cancel = 1'b1;
    coin(3);
    cancel = 1'b0;
    chk("C rej+cancel", int'(rej_o[2]), 1);
    chk("C busy rej+cancel", int'(busy_o[2]), 1);
    chk("C credit rej+cancel", int'(cr_o[2]), 14);

    // coin and cancel while refunding
    cancel = 1'b1;
    coin(2);
    cancel = 1'b0;
    chk("C rej refund", int'(rej_o[2]), 1);
    chk("C credit refund", int'(cr_o[2]), 14);
    chk("C busy refund", int'(busy_o[2]), 1);
    tick();
    chk("C rej pulse", int'(rej_o[2]), 0);
    chg_rdy = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      done = !busy_o[0] && !busy_o[1] && !busy_o[2];
    end
    chg_rdy = 1'b0;
    chk("drain timeout", int'(done), 1);

    // random traffic
    do_reset();
    f0 = n_fail;
    for (int i = 0; i < 512; i++) begin
      coin_vld = ($urandom_range(9) < 4);
      coin_val = 2'($urandom_range(3));
      cancel   = ($urandom_range(9) == 0);
      chg_rdy  = ($urandom_range(1) == 1);
      tick();
      if (n_fail != f0) break;
    end
    coin_vld = 1'b0; coin_val = 2'd0;
    cancel = 1'b0; chg_rdy = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
